// File: rtl/alu_defs_pkg.sv
// Shared ALU/pipeline definitions.
//   - 3-bit ALU operation codes driven on the Ctrl bus.
//   - Bit positions inside the 6-bit decoded control word Id_Ctl,
//     laid out as {AluSrc, RegDst, MemRead, MemWrite, RegWrite, MemToReg}.
//   - Default datapath and register-number widths.
package alu_defs_pkg;

  localparam int unsigned DefW  = 32;
  localparam int unsigned DefRw = 5;

  localparam logic [2:0] AluAdd = 3'b000;
  localparam logic [2:0] AluLw  = 3'b001;
  localparam logic [2:0] AluSw  = 3'b010;
  localparam logic [2:0] AluAnd = 3'b011;
  localparam logic [2:0] AluNor = 3'b100;
  localparam logic [2:0] AluSll = 3'b101;
  localparam logic [2:0] AluBeq = 3'b110;
  localparam logic [2:0] AluSlt = 3'b111;

  localparam int unsigned CtlAluSrc   = 5;
  localparam int unsigned CtlRegDst   = 4;
  localparam int unsigned CtlMemRead  = 3;
  localparam int unsigned CtlMemWrite = 2;
  localparam int unsigned CtlRegWrite = 1;
  localparam int unsigned CtlMemToReg = 0;

endpackage

// File: rtl/fwd_mux.sv
// Operand bypass mux for one source register.
//   reg_num      register number held in the EX slot
//   reg_val      register-file value captured with it
//   mem_regwrite/mem_rd/mem_result  EX/MEM bypass source
//   wb_regwrite/wb_rd/wb_data       MEM/WB bypass source
//   operand      forwarded value
// Register 0 is hard-wired, so it is never bypassed. EX/MEM is the younger
// result and therefore wins over MEM/WB.
module fwd_mux #(
  parameter int unsigned W  = 32,
  parameter int unsigned RW = 5
) (
  input  logic [RW-1:0] reg_num,
  input  logic [W-1:0]  reg_val,
  input  logic          mem_regwrite,
  input  logic [RW-1:0] mem_rd,
  input  logic [W-1:0]  mem_result,
  input  logic          wb_regwrite,
  input  logic [RW-1:0] wb_rd,
  input  logic [W-1:0]  wb_data,
  output logic [W-1:0]  operand
);

  always_comb begin
    operand = reg_val;
    if (reg_num != '0) begin
      if (mem_regwrite && (mem_rd == reg_num)) begin
        operand = mem_result;
      end else if (wb_regwrite && (wb_rd == reg_num)) begin
        operand = wb_data;
      end
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding and load-use detection.
// Inputs : Clk, Rst_n (sync, active-low), decode slot (Id_*), Hold, Flush,
//          EX/MEM bypass (Mem_*), MEM/WB bypass (Wb_*).
// Outputs: In1/In2/Ctrl to the ALU, Ex_StoreData, Ex_WriteReg, registered
//          memory/write-back controls, Ex_Valid, and combinational Stall_Req.
// Edge priority: reset > Flush (bubble) > Hold (keep) > Stall_Req (bubble)
// > load decode slot.
module id_ex_stage import alu_defs_pkg::*; #(
  parameter int unsigned W  = DefW,
  parameter int unsigned RW = DefRw
) (
  input  logic          Clk,
  input  logic          Rst_n,
  input  logic          Id_Valid,
  input  logic [W-1:0]  Id_Rs_Data,
  input  logic [W-1:0]  Id_Rt_Data,
  input  logic [W-1:0]  Id_Imm,
  input  logic [4:0]    Id_Shamt,
  input  logic [RW-1:0] Id_Rs,
  input  logic [RW-1:0] Id_Rt,
  input  logic [RW-1:0] Id_Rd,
  input  logic [2:0]    Id_AluCtrl,
  input  logic [5:0]    Id_Ctl,
  input  logic          Hold,
  input  logic          Flush,
  input  logic          Mem_RegWrite,
  input  logic [RW-1:0] Mem_Rd,
  input  logic [W-1:0]  Mem_Result,
  input  logic          Wb_RegWrite,
  input  logic [RW-1:0] Wb_Rd,
  input  logic [W-1:0]  Wb_Data,
  output logic [W-1:0]  In1,
  output logic [W-1:0]  In2,
  output logic [2:0]    Ctrl,
  output logic [W-1:0]  Ex_StoreData,
  output logic [RW-1:0] Ex_WriteReg,
  output logic          Ex_MemRead,
  output logic          Ex_MemWrite,
  output logic          Ex_RegWrite,
  output logic          Ex_MemToReg,
  output logic          Ex_Valid,
  output logic          Stall_Req
);

  logic          ex_valid_q;
  logic [2:0]    alu_op_q;
  logic          alu_src_q;
  logic          mem_read_q;
  logic          mem_write_q;
  logic          reg_write_q;
  logic          mem_to_reg_q;
  logic [RW-1:0] write_reg_q;
  logic [RW-1:0] rs_q;
  logic [RW-1:0] rt_q;
  logic [W-1:0]  rs_data_q;
  logic [W-1:0]  rt_data_q;
  logic [W-1:0]  imm_q;
  logic [4:0]    shamt_q;

  logic [W-1:0]  fwd_rs;
  logic [W-1:0]  fwd_rt;
  logic          stall;

  // A load in EX cannot forward its data in time for the instruction in ID.
  // rt only matters when it is read as an operand (no immediate) or as store data.
  assign stall = ex_valid_q && mem_read_q && (write_reg_q != '0) && Id_Valid &&
                 ((write_reg_q == Id_Rs) ||
                  ((write_reg_q == Id_Rt) &&
                   (!Id_Ctl[CtlAluSrc] || Id_Ctl[CtlMemWrite])));

  always_ff @(posedge Clk) begin
    if (!Rst_n || Flush || (!Hold && stall)) begin
      // Bubble: clearing rs/rt to 0 also disables any forwarding.
      ex_valid_q   <= 1'b0;
      alu_op_q     <= AluAdd;
      alu_src_q    <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      reg_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      write_reg_q  <= '0;
      rs_q         <= '0;
      rt_q         <= '0;
      rs_data_q    <= '0;
      rt_data_q    <= '0;
      imm_q        <= '0;
      shamt_q      <= '0;
    end else if (!Hold) begin
      ex_valid_q   <= Id_Valid;
      alu_op_q     <= Id_AluCtrl;
      alu_src_q    <= Id_Ctl[CtlAluSrc];
      mem_read_q   <= Id_Ctl[CtlMemRead];
      mem_write_q  <= Id_Ctl[CtlMemWrite];
      reg_write_q  <= Id_Ctl[CtlRegWrite];
      mem_to_reg_q <= Id_Ctl[CtlMemToReg];
      write_reg_q  <= Id_Ctl[CtlRegDst] ? Id_Rd : Id_Rt;
      rs_q         <= Id_Rs;
      rt_q         <= Id_Rt;
      rs_data_q    <= Id_Rs_Data;
      rt_data_q    <= Id_Rt_Data;
      imm_q        <= Id_Imm;
      shamt_q      <= Id_Shamt;
    end
  end

  fwd_mux #(
    .W  (W),
    .RW (RW)
  ) u_fwd_rs (
    .reg_num      (rs_q),
    .reg_val      (rs_data_q),
    .mem_regwrite (Mem_RegWrite),
    .mem_rd       (Mem_Rd),
    .mem_result   (Mem_Result),
    .wb_regwrite  (Wb_RegWrite),
    .wb_rd        (Wb_Rd),
    .wb_data      (Wb_Data),
    .operand      (fwd_rs)
  );

  fwd_mux #(
    .W  (W),
    .RW (RW)
  ) u_fwd_rt (
    .reg_num      (rt_q),
    .reg_val      (rt_data_q),
    .mem_regwrite (Mem_RegWrite),
    .mem_rd       (Mem_Rd),
    .mem_result   (Mem_Result),
    .wb_regwrite  (Wb_RegWrite),
    .wb_rd        (Wb_Rd),
    .wb_data      (Wb_Data),
    .operand      (fwd_rt)
  );

  // sll shifts the rt value by shamt; everything else is rs op (imm | rt).
  always_comb begin
    if (alu_op_q == AluSll) begin
      In1 = fwd_rt;
      In2 = {{(W-5){1'b0}}, shamt_q};
    end else begin
      In1 = fwd_rs;
      In2 = alu_src_q ? imm_q : fwd_rt;
    end
  end

  assign Ctrl         = alu_op_q;
  assign Ex_StoreData = fwd_rt;
  assign Ex_WriteReg  = write_reg_q;
  assign Ex_MemRead   = mem_read_q;
  assign Ex_MemWrite  = mem_write_q;
  assign Ex_RegWrite  = reg_write_q;
  assign Ex_MemToReg  = mem_to_reg_q;
  assign Ex_Valid     = ex_valid_q;
  assign Stall_Req    = stall;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: constant vector table, hand-written multi-cycle
// sequences (reset, load-use, flush/hold/reset), then randomized cycles
// checked against a behavioural model of the EX slot.
module tb_id_ex_stage;

  typedef struct packed {
    logic        valid;
    logic [31:0] rs_d;
    logic [31:0] rt_d;
    logic [31:0] imm;
    logic [4:0]  shamt;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [2:0]  op;
    logic [5:0]  ctl;  // {AluSrc,RegDst,MemRead,MemWrite,RegWrite,MemToReg}
  } instr_t;

  typedef struct packed {
    instr_t      in;
    logic        mrw;
    logic [4:0]  mrd;
    logic [31:0] mres;
    logic        wrw;
    logic [4:0]  wrd;
    logic [31:0] wdat;
    logic [31:0] e_in1;
    logic [31:0] e_in2;
    logic [31:0] e_sd;
    logic [2:0]  e_ctrl;
    logic [4:0]  e_wr;
  } vec_t;

  localparam logic [5:0] CtlR    = 6'b010010;  // RegDst, RegWrite
  localparam logic [5:0] CtlAddi = 6'b100010;  // AluSrc, RegWrite
  localparam logic [5:0] CtlLw   = 6'b101011;  // AluSrc, MemRead, RegWrite, MemToReg
  localparam logic [5:0] CtlSw   = 6'b100100;  // AluSrc, MemWrite

  logic        Clk = 1'b0;
  logic        Rst_n;
  instr_t      id;
  logic        Hold, Flush;
  logic        Mem_RegWrite, Wb_RegWrite;
  logic [4:0]  Mem_Rd, Wb_Rd;
  logic [31:0] Mem_Result, Wb_Data;
  logic [31:0] In1, In2, Ex_StoreData;
  logic [2:0]  Ctrl;
  logic [4:0]  Ex_WriteReg;
  logic        Ex_MemRead, Ex_MemWrite, Ex_RegWrite, Ex_MemToReg, Ex_Valid, Stall_Req;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 Clk = ~Clk;

  id_ex_stage dut (
    .Clk          (Clk),
    .Rst_n        (Rst_n),
    .Id_Valid     (id.valid),
    .Id_Rs_Data   (id.rs_d),
    .Id_Rt_Data   (id.rt_d),
    .Id_Imm       (id.imm),
    .Id_Shamt     (id.shamt),
    .Id_Rs        (id.rs),
    .Id_Rt        (id.rt),
    .Id_Rd        (id.rd),
    .Id_AluCtrl   (id.op),
    .Id_Ctl       (id.ctl),
    .Hold         (Hold),
    .Flush        (Flush),
    .Mem_RegWrite (Mem_RegWrite),
    .Mem_Rd       (Mem_Rd),
    .Mem_Result   (Mem_Result),
    .Wb_RegWrite  (Wb_RegWrite),
    .Wb_Rd        (Wb_Rd),
    .Wb_Data      (Wb_Data),
    .In1          (In1),
    .In2          (In2),
    .Ctrl         (Ctrl),
    .Ex_StoreData (Ex_StoreData),
    .Ex_WriteReg  (Ex_WriteReg),
    .Ex_MemRead   (Ex_MemRead),
    .Ex_MemWrite  (Ex_MemWrite),
    .Ex_RegWrite  (Ex_RegWrite),
    .Ex_MemToReg  (Ex_MemToReg),
    .Ex_Valid     (Ex_Valid),
    .Stall_Req    (Stall_Req)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic instr_t mk(input logic v, input logic [31:0] rsd, input logic [31:0] rtd,
                                input logic [31:0] imm, input logic [4:0] sh,
                                input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                                input logic [2:0] op, input logic [5:0] ctl);
    instr_t i;
    i.valid = v; i.rs_d = rsd; i.rt_d = rtd; i.imm = imm; i.shamt = sh;
    i.rs = rs; i.rt = rt; i.rd = rd; i.op = op; i.ctl = ctl;
    return i;
  endfunction

  // ---------------- behavioural model: the instruction sitting in EX ----------
  instr_t m_ex;

  function automatic logic [4:0] m_dest(input instr_t i);
    return i.ctl[4] ? i.rd : i.rt;
  endfunction

  function automatic logic [31:0] m_fwd(input logic [4:0] r, input logic [31:0] v);
    if (r == 0) return v;
    if (Mem_RegWrite && Mem_Rd == r) return Mem_Result;
    if (Wb_RegWrite && Wb_Rd == r) return Wb_Data;
    return v;
  endfunction

  function automatic logic m_stall();
    logic [4:0] d;
    d = m_dest(m_ex);
    if (!(m_ex.valid && m_ex.ctl[3] && d != 0 && id.valid)) return 1'b0;
    return (d == id.rs) || (d == id.rt && (!id.ctl[5] || id.ctl[2]));
  endfunction

  task automatic check_model();
    logic [31:0] frs, frt, e1, e2;
    frs = m_fwd(m_ex.rs, m_ex.rs_d);
    frt = m_fwd(m_ex.rt, m_ex.rt_d);
    if (m_ex.op == 3'b101) begin
      e1 = frt; e2 = 32'(m_ex.shamt);
    end else begin
      e1 = frs; e2 = m_ex.ctl[5] ? m_ex.imm : frt;
    end
    chk("rnd_in1", In1, e1);
    chk("rnd_in2", In2, e2);
    chk("rnd_ctrl", 32'(Ctrl), 32'(m_ex.op));
    chk("rnd_store", Ex_StoreData, frt);
    chk("rnd_wreg", 32'(Ex_WriteReg), 32'(m_dest(m_ex)));
    chk("rnd_ctl", {28'd0, Ex_MemRead, Ex_MemWrite, Ex_RegWrite, Ex_MemToReg},
        {28'd0, m_ex.ctl[3], m_ex.ctl[2], m_ex.ctl[1], m_ex.ctl[0]});
    chk("rnd_valid", 32'(Ex_Valid), 32'(m_ex.valid));
    chk("rnd_stall", 32'(Stall_Req), 32'(m_stall()));
  endtask

  // One clock edge; the model applies the edge-priority rules to the same inputs.
  task automatic tick();
    logic st;
    st = m_stall();
    @(posedge Clk);
    if (!Rst_n || Flush) m_ex = '0;
    else if (Hold) m_ex = m_ex;
    else if (st) m_ex = '0;
    else m_ex = id;
    #1;
  endtask

  task automatic clr_bypass();
    Mem_RegWrite = 0; Mem_Rd = 0; Mem_Result = 0;
    Wb_RegWrite = 0; Wb_Rd = 0; Wb_Data = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1);
  end

  vec_t vecs[8];

  initial begin
    vecs[0] = '{in: mk(1, 5, 7, 0, 0, 1, 2, 3, 3'b000, CtlR), mrw: 0, mrd: 0, mres: 0,
                wrw: 0, wrd: 0, wdat: 0, e_in1: 5, e_in2: 7, e_sd: 7, e_ctrl: 0, e_wr: 3};
    vecs[1] = '{in: mk(1, 11, 7, 0, 0, 1, 2, 3, 3'b000, CtlR), mrw: 1, mrd: 1, mres: 9,
                wrw: 1, wrd: 1, wdat: 4, e_in1: 9, e_in2: 7, e_sd: 7, e_ctrl: 0, e_wr: 3};
    vecs[2] = '{in: mk(1, 11, 7, 0, 0, 1, 2, 3, 3'b000, CtlR), mrw: 0, mrd: 1, mres: 9,
                wrw: 1, wrd: 1, wdat: 4, e_in1: 4, e_in2: 7, e_sd: 7, e_ctrl: 0, e_wr: 3};
    vecs[3] = '{in: mk(1, 11, 7, 0, 0, 0, 2, 3, 3'b011, CtlR), mrw: 1, mrd: 0, mres: 9,
                wrw: 1, wrd: 0, wdat: 4, e_in1: 11, e_in2: 7, e_sd: 7, e_ctrl: 3, e_wr: 3};
    vecs[4] = '{in: mk(1, 1, 2, 0, 0, 1, 2, 6, 3'b111, CtlR), mrw: 1, mrd: 2, mres: 32'h55,
                wrw: 1, wrd: 2, wdat: 32'h66, e_in1: 1, e_in2: 32'h55, e_sd: 32'h55,
                e_ctrl: 7, e_wr: 6};
    vecs[5] = '{in: mk(1, 1, 2, 32'hFFFF_FFF0, 0, 1, 2, 9, 3'b000, CtlAddi), mrw: 1, mrd: 2,
                mres: 32'h55, wrw: 0, wrd: 0, wdat: 0, e_in1: 1, e_in2: 32'hFFFF_FFF0,
                e_sd: 32'h55, e_ctrl: 0, e_wr: 2};
    vecs[6] = '{in: mk(1, 0, 4, 0, 7, 0, 2, 4, 3'b101, CtlR), mrw: 0, mrd: 0, mres: 0,
                wrw: 0, wrd: 0, wdat: 0, e_in1: 4, e_in2: 7, e_sd: 4, e_ctrl: 5, e_wr: 4};
    vecs[7] = '{in: mk(1, 0, 4, 0, 31, 0, 2, 4, 3'b101, CtlR), mrw: 0, mrd: 0, mres: 0,
                wrw: 1, wrd: 2, wdat: 32'h80, e_in1: 32'h80, e_in2: 31, e_sd: 32'h80,
                e_ctrl: 5, e_wr: 4};

    // T1: reset with a live load in the decode slot.
    m_ex = '0;
    Rst_n = 0; Hold = 0; Flush = 0; clr_bypass();
    id = mk(1, 3, 4, 5, 6, 1, 2, 3, 3'b001, CtlLw);
    tick(); tick();
    chk("rst_valid", 32'(Ex_Valid), 0);
    chk("rst_ctrl", 32'(Ctrl), 0);
    chk("rst_ctl", {Ex_MemRead, Ex_MemWrite, Ex_RegWrite, Ex_MemToReg}, 0);
    chk("rst_stall", 32'(Stall_Req), 0);
    chk("rst_in1", In1, 0);
    chk("rst_in2", In2, 0);
    chk("rst_wreg", 32'(Ex_WriteReg), 0);
    Rst_n = 1;

    // T2/T3/T5 and friends: vector table.
    for (int k = 0; k < 8; k++) begin
      id = vecs[k].in;
      clr_bypass();
      tick();
      Mem_RegWrite = vecs[k].mrw; Mem_Rd = vecs[k].mrd; Mem_Result = vecs[k].mres;
      Wb_RegWrite = vecs[k].wrw; Wb_Rd = vecs[k].wrd; Wb_Data = vecs[k].wdat;
      #1;
      chk($sformatf("vec%0d_in1", k), In1, vecs[k].e_in1);
      chk($sformatf("vec%0d_in2", k), In2, vecs[k].e_in2);
      chk($sformatf("vec%0d_store", k), Ex_StoreData, vecs[k].e_sd);
      chk($sformatf("vec%0d_ctrl", k), 32'(Ctrl), 32'(vecs[k].e_ctrl));
      chk($sformatf("vec%0d_wreg", k), 32'(Ex_WriteReg), 32'(vecs[k].e_wr));
      chk($sformatf("vec%0d_valid", k), 32'(Ex_Valid), 1);
    end
    clr_bypass();

    // T4: lw $2 followed by add $3,$2,$5.
    id = mk(1, 32'h100, 0, 4, 0, 1, 2, 0, 3'b001, CtlLw);
    tick();
    id = mk(1, 0, 32'h77, 0, 0, 2, 5, 3, 3'b000, CtlR);
    #1;
    chk("lu_stall_on", 32'(Stall_Req), 1);
    tick();
    chk("lu_bubble_valid", 32'(Ex_Valid), 0);
    chk("lu_bubble_memrd", 32'(Ex_MemRead), 0);
    chk("lu_stall_off", 32'(Stall_Req), 0);
    tick();
    id = '0;
    Wb_RegWrite = 1; Wb_Rd = 2; Wb_Data = 32'h1234;
    #1;
    chk("lu_add_valid", 32'(Ex_Valid), 1);
    chk("lu_add_in1", In1, 32'h1234);
    chk("lu_add_in2", In2, 32'h77);
    chk("lu_add_wreg", 32'(Ex_WriteReg), 3);
    clr_bypass();

    // Load-use boundaries: rt used as immediate-source, as store data, $0 load.
    id = mk(1, 32'h100, 0, 4, 0, 1, 2, 0, 3'b001, CtlLw);
    tick();
    id = mk(1, 0, 0, 8, 0, 5, 2, 0, 3'b000, CtlAddi);
    #1 chk("lu_addi_rt", 32'(Stall_Req), 0);
    id = mk(1, 0, 0, 8, 0, 5, 2, 0, 3'b010, CtlSw);
    #1 chk("lu_sw_rt", 32'(Stall_Req), 1);
    id = mk(0, 0, 0, 0, 0, 2, 2, 0, 3'b000, 6'b0);
    #1 chk("lu_id_invalid", 32'(Stall_Req), 0);
    id = mk(1, 32'h100, 0, 4, 0, 1, 0, 0, 3'b001, CtlLw);
    tick();
    id = mk(1, 0, 0, 0, 0, 0, 0, 3, 3'b000, CtlR);
    #1 chk("lu_zero_dest", 32'(Stall_Req), 0);

    // T6: Flush+Hold loads a bubble; Hold freezes; reset overrides Hold.
    id = mk(1, 32'hAA, 32'hBB, 0, 0, 1, 2, 3, 3'b000, CtlR);
    tick();
    Flush = 1; Hold = 1;
    id = mk(1, 32'hCC, 32'hDD, 0, 0, 1, 2, 7, 3'b011, CtlR);
    tick();
    chk("fh_valid", 32'(Ex_Valid), 0);
    chk("fh_in1", In1, 0);
    chk("fh_ctrl", 32'(Ctrl), 0);
    chk("fh_regwr", 32'(Ex_RegWrite), 0);
    Flush = 0; Hold = 0;
    id = mk(1, 32'h11, 32'h22, 0, 0, 1, 2, 3, 3'b000, CtlR);
    tick();
    Hold = 1;
    id = mk(1, 32'h99, 32'h98, 0, 0, 4, 5, 9, 3'b111, CtlAddi);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("hold%0d_in1", c), In1, 32'h11);
      chk($sformatf("hold%0d_in2", c), In2, 32'h22);
      chk($sformatf("hold%0d_ctrl", c), 32'(Ctrl), 0);
      chk($sformatf("hold%0d_wreg", c), 32'(Ex_WriteReg), 3);
      chk($sformatf("hold%0d_valid", c), 32'(Ex_Valid), 1);
    end
    Rst_n = 0;
    tick();
    chk("hrst_valid", 32'(Ex_Valid), 0);
    chk("hrst_in1", In1, 0);
    chk("hrst_wreg", 32'(Ex_WriteReg), 0);
    chk("hrst_regwr", 32'(Ex_RegWrite), 0);
    Rst_n = 1; Hold = 0;

    // Randomized cycles against the model; small register numbers force hazards.
    for (int c = 0; c < 400; c++) begin
      id.valid = ($urandom_range(0, 9) != 0);
      id.rs_d  = $urandom;
      id.rt_d  = $urandom;
      id.imm   = $urandom;
      id.shamt = 5'($urandom);
      id.rs    = 5'($urandom_range(0, 3));
      id.rt    = 5'($urandom_range(0, 3));
      id.rd    = 5'($urandom_range(0, 3));
      id.op    = 3'($urandom);
      id.ctl   = id.valid ? 6'($urandom) : 6'b0;
      if (id.valid && $urandom_range(0, 2) == 0) begin
        id.ctl = CtlLw; id.op = 3'b001;
      end
      Flush        = ($urandom_range(0, 9) == 0);
      Hold         = ($urandom_range(0, 6) == 0);
      Rst_n        = ($urandom_range(0, 49) != 0);
      Mem_RegWrite = 1'($urandom);
      Mem_Rd       = 5'($urandom_range(0, 3));
      Mem_Result   = $urandom;
      Wb_RegWrite  = 1'($urandom);
      Wb_Rd        = 5'($urandom_range(0, 3));
      Wb_Data      = $urandom;
      @(negedge Clk);
      check_model();
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
